// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard controller.
package pipeline_pkg;

    // EX_MEM_Branch codes; 2'b11 is reserved and never redirects
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;

    // pc_sel codes
    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_J   = 2'b10;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // next value: increment unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // count register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use bubble insertion, MEM-stage redirect squash, post-reset fill
// masking and stall/flush performance counters for a 5-stage pipeline.
//
// state | meaning
// FILL  | pipeline filling after reset; redirects ignored, stalls honoured
// RUN   | filled; redirects honoured (terminal until reset)
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int FILL_CYCLES = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rt,
    input  logic             ID_EX_MemtoReg,
    input  logic [4:0]       ID_EX_wreg,
    input  logic [1:0]       EX_MEM_Branch,
    input  logic             EX_MEM_zero,
    input  logic             EX_MEM_Jump,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic [1:0]       pc_sel,
    output logic             ready,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int FW = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
    localparam logic [FW-1:0] FCNT_LAST = FW'(FILL_CYCLES - 1);

    state_e        state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          taken;
    logic          lu;

    // fill sequencing: count up to FCNT_LAST, then move to RUN for good
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (state_q == ST_FILL) begin
            if (fcnt_q == FCNT_LAST) begin
                state_d = ST_RUN;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    // state and fill-count registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FILL;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign ready = (state_q == ST_RUN) && !reset;

    // hazard detection; $0 is never a real producer, branch code 11 is inert
    always_comb begin
        taken = (state_q == ST_RUN) &&
                (EX_MEM_Jump ||
                 ((EX_MEM_Branch == BR_BEQ) &&  EX_MEM_zero) ||
                 ((EX_MEM_Branch == BR_BNE) && !EX_MEM_zero));
        lu    = ID_EX_MemtoReg && (ID_EX_wreg != 5'd0) &&
                ((ID_EX_wreg == ID_rs) || (ID_uses_rt && (ID_EX_wreg == ID_rt)));
    end

    // priority mux: reset hold, redirect, load-use bubble, normal flow
    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        pc_sel       = PCSEL_SEQ;
        if (reset) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
        end else if (taken) begin
            // a coincident load-use is dropped: its instruction is squashed anyway
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            pc_sel       = EX_MEM_Jump ? PCSEL_J : PCSEL_BR;
        end else if (lu) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_flush  = 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (lu && !taken),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (taken),
        .count (flush_cnt)
    );

endmodule
